// File: rtl/param_register_file.sv
// Two-read/one-write register bank with a post-reset clear sweep, optional
// hardwired zero entry and optional same-cycle write-to-read forwarding.
//
// state | meaning
// CLEAR | sweeping bank to zero, one entry per cycle; writes dropped, reads 0
// RUN   | normal operation: registered reads, writes at posedge
module param_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] registerAddressA,
   input  logic [ADDR_WIDTH-1:0] registerAddressB,
   input  logic [ADDR_WIDTH-1:0] registerAddressC,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  writeEnable,
   output logic [DATA_WIDTH-1:0] registerDataA,
   output logic [DATA_WIDTH-1:0] registerDataB,
   output logic                  ready,
   output logic                  writeDropped
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_INDEX = (ADDR_WIDTH + 1)'(DEPTH - 1);
   localparam bit ZERO_EN   = (ZERO_REG != 0);
   localparam bit BYPASS_EN = (BYPASS != 0);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                  state;
   logic [ADDR_WIDTH:0]     clear_index;
   logic [DATA_WIDTH-1:0]   bank [DEPTH];

   logic                    write_ok;
   logic                    bank_we;
   logic [ADDR_WIDTH-1:0]   bank_addr;
   logic [DATA_WIDTH-1:0]   bank_data;
   logic [DATA_WIDTH-1:0]   next_a;
   logic [DATA_WIDTH-1:0]   next_b;

   // Writes to the zero entry vanish without a writeDropped pulse.
   assign write_ok = (state == RUN) && writeEnable &&
                     !(ZERO_EN && (registerAddressC == '0));

   // The sweep and the write port share the single array write port.
   assign bank_we   = !reset && ((state == CLEAR) || write_ok);
   assign bank_addr = (state == CLEAR) ? clear_index[ADDR_WIDTH-1:0] : registerAddressC;
   assign bank_data = (state == CLEAR) ? '0 : writeData;

   always_ff @(posedge clock) begin
      if (bank_we) bank[bank_addr] <= bank_data;
   end

   always_comb begin
      next_a = bank[registerAddressA];
      if (BYPASS_EN && write_ok && (registerAddressA == registerAddressC)) next_a = writeData;
      if (ZERO_EN && (registerAddressA == '0)) next_a = '0;
   end

   always_comb begin
      next_b = bank[registerAddressB];
      if (BYPASS_EN && write_ok && (registerAddressB == registerAddressC)) next_b = writeData;
      if (ZERO_EN && (registerAddressB == '0)) next_b = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= CLEAR;
         clear_index   <= '0;
         registerDataA <= '0;
         registerDataB <= '0;
         ready         <= 1'b0;
         writeDropped  <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clear_index   <= clear_index + 1'b1;
               registerDataA <= '0;
               registerDataB <= '0;
               writeDropped  <= writeEnable;
               if (clear_index == LAST_INDEX) state <= RUN;
            end
            RUN: begin
               registerDataA <= next_a;
               registerDataB <= next_b;
               writeDropped  <= 1'b0;
            end
            default: state <= CLEAR;
         endcase
         ready <= (state == RUN);
      end
   end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: three instances (defaults,
// no zero-reg/no bypass, and a 16x8 variant) driven by directed vectors.
module tb_param_register_file;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  addr_a, addr_b, addr_c;
   logic [31:0] wdata;
   logic        we;
   logic [2:0]  sa, sb, sc;
   logic [15:0] sdata;
   logic        swe;

   logic [31:0] a0, b0, a1, b1;
   logic [15:0] a2, b2;
   logic        rdy0, wd0, rdy1, wd1, rdy2, wd2;

   always #5 clock = ~clock;

   param_register_file dut0 (
      .clock(clock), .reset(reset),
      .registerAddressA(addr_a), .registerAddressB(addr_b), .registerAddressC(addr_c),
      .writeData(wdata), .writeEnable(we),
      .registerDataA(a0), .registerDataB(b0), .ready(rdy0), .writeDropped(wd0));

   param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
      .clock(clock), .reset(reset),
      .registerAddressA(addr_a), .registerAddressB(addr_b), .registerAddressC(addr_c),
      .writeData(wdata), .writeEnable(we),
      .registerDataA(a1), .registerDataB(b1), .ready(rdy1), .writeDropped(wd1));

   param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut2 (
      .clock(clock), .reset(reset),
      .registerAddressA(sa), .registerAddressB(sb), .registerAddressC(sc),
      .writeData(sdata), .writeEnable(swe),
      .registerDataA(a2), .registerDataB(b2), .ready(rdy2), .writeDropped(wd2));

   typedef struct {
      int          due;
      int          unit;
      int          sig;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   localparam int SA = 0, SB = 1, SR = 2, SW = 3;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int unit, input int sig);
      logic [31:0] v;
      v = 32'hx;
      if (unit == 0) begin
         if (sig == SA) v = a0; else if (sig == SB) v = b0;
         else if (sig == SR) v = {31'd0, rdy0}; else v = {31'd0, wd0};
      end else if (unit == 1) begin
         if (sig == SA) v = a1; else if (sig == SB) v = b1;
         else if (sig == SR) v = {31'd0, rdy1}; else v = {31'd0, wd1};
      end else begin
         if (sig == SA) v = {16'd0, a2}; else if (sig == SB) v = {16'd0, b2};
         else if (sig == SR) v = {31'd0, rdy2}; else v = {31'd0, wd2};
      end
      return v;
   endfunction

   // Monitor: resolves every expectation due at this edge
   always @(posedge clock) begin
      exp_t        e;
      logic [31:0] act;
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e   = sbq.pop_front();
         act = actual(e.unit, e.sig);
         total++;
         if (act !== e.exp) begin
            bad++;
            $display("FAIL %s unit%0d cyc%0d: got %h expected %h", e.name, e.unit, cyc, act, e.exp);
         end
      end
   end

   task automatic push(input int unit, input int sig, input string name, input logic [31:0] exp);
      exp_t e;
      e.due = cyc + 1; e.unit = unit; e.sig = sig; e.exp = exp; e.name = name;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic idle_main();
      we = 1'b0; addr_a = '0; addr_b = '0; addr_c = '0; wdata = '0;
   endtask

   task automatic idle_small();
      swe = 1'b0; sa = '0; sb = '0; sc = '0; sdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle_main();
      idle_small();

      // reset state
      for (int k = 0; k < 2; k++) begin
         for (int u = 0; u < 3; u++) begin
            push(u, SA, "rst_data_a", 32'd0);
            push(u, SB, "rst_data_b", 32'd0);
            push(u, SR, "rst_ready", 32'd0);
            push(u, SW, "rst_dropped", 32'd0);
         end
         step();
      end
      reset = 1'b0;

      // first sweep: dropped writes at cycle 5 (main) and cycle 3 (small)
      for (int i = 1; i <= 33; i++) begin
         idle_main();
         idle_small();
         if (i == 5) begin we = 1'b1; addr_c = 5'd3; wdata = 32'h0000_DEAD; end
         if (i == 3) begin swe = 1'b1; sc = 3'd2; sdata = 16'hABCD; end
         push(0, SR, "sweep_ready", {31'd0, i >= 33});
         push(1, SR, "sweep_ready", {31'd0, i >= 33});
         push(2, SR, "sweep_ready", {31'd0, i >= 9});
         push(0, SW, "sweep_dropped", {31'd0, i == 5});
         push(1, SW, "sweep_dropped", {31'd0, i == 5});
         push(2, SW, "sweep_dropped", {31'd0, i == 3});
         if (i <= 8) push(2, SA, "sweep_data_zero", 32'd0);
         step();
      end

      // dropped write to r3 never landed
      idle_main(); addr_a = 5'd3;
      push(0, SA, "r3_cleared", 32'd0);
      push(1, SA, "r3_cleared", 32'd0);
      step();

      // write/read latency
      idle_main(); we = 1'b1; addr_c = 5'd7; wdata = 32'h1234_5678;
      step();
      idle_main(); addr_a = 5'd7;
      push(0, SA, "lat_a", 32'h1234_5678);
      push(0, SB, "lat_b_r0", 32'd0);
      push(1, SA, "lat_a", 32'h1234_5678);
      push(1, SB, "lat_b_r0", 32'd0);
      step();

      // zero register
      idle_main(); we = 1'b1; addr_c = 5'd0; wdata = 32'hFFFF_FFFF;
      push(0, SA, "zero_same_cycle", 32'd0);
      push(1, SA, "nozero_same_cycle_old", 32'd0);
      push(0, SW, "zero_no_drop", 32'd0);
      step();
      idle_main();
      push(0, SA, "zero_read", 32'd0);
      push(1, SA, "nozero_read", 32'hFFFF_FFFF);
      push(0, SW, "run_no_drop", 32'd0);
      step();

      // bypass
      idle_main(); we = 1'b1; addr_c = 5'd5; wdata = 32'h11;
      step();
      idle_main(); we = 1'b1; addr_c = 5'd5; wdata = 32'h22; addr_a = 5'd5; addr_b = 5'd5;
      push(0, SA, "bypass_a", 32'h22);
      push(0, SB, "bypass_b", 32'h22);
      push(1, SA, "nobypass_a", 32'h11);
      push(1, SB, "nobypass_b", 32'h11);
      step();
      idle_main(); we = 1'b1; addr_c = 5'd7; wdata = 32'h33; addr_a = 5'd7; addr_b = 5'd5;
      push(0, SA, "bypass_indep_a", 32'h33);
      push(0, SB, "after_write_b", 32'h22);
      push(1, SA, "nobypass_indep_a", 32'h1234_5678);
      push(1, SB, "after_write_b", 32'h22);
      step();
      idle_main(); addr_a = 5'd7; addr_b = 5'd5;
      push(0, SA, "r7_new", 32'h33);
      push(1, SA, "r7_new", 32'h33);
      push(1, SB, "r5_new", 32'h22);
      step();

      // small instance: r7 and r0
      idle_main();
      swe = 1'b1; sc = 3'd7; sdata = 16'hBEEF;
      step();
      idle_small(); swe = 1'b1; sc = 3'd0; sdata = 16'hFFFF; sa = 3'd7; sb = 3'd2;
      push(2, SA, "small_r7", 32'h0000_BEEF);
      push(2, SB, "small_r2_cleared", 32'd0);
      step();
      idle_small(); sa = 3'd0;
      push(2, SA, "small_r0", 32'd0);
      push(2, SW, "small_no_drop", 32'd0);
      step();
      idle_small();

      // reset mid-sweep
      reset = 1'b1;
      push(0, SR, "rst2_ready", 32'd0);
      step();
      reset = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         push(0, SR, "mid_ready", 32'd0);
         push(2, SR, "mid_small_ready", {31'd0, i >= 9});
         step();
      end
      reset = 1'b1;
      push(0, SA, "mid_rst_data", 32'd0);
      push(0, SR, "mid_rst_ready", 32'd0);
      step();
      reset = 1'b0;
      for (int j = 1; j <= 33; j++) begin
         push(0, SR, "restart_ready", {31'd0, j >= 33});
         push(1, SR, "restart_ready", {31'd0, j >= 33});
         step();
      end
      idle_main(); addr_a = 5'd7; addr_b = 5'd5;
      push(0, SA, "restart_r7", 32'd0);
      push(0, SB, "restart_r5", 32'd0);
      push(1, SA, "restart_r7", 32'd0);
      push(1, SB, "restart_r5", 32'd0);
      step();
      idle_main(); addr_a = 5'd0;
      push(1, SA, "restart_r0", 32'd0);
      step();
      idle_main();
      step();
      step();

      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
